// File: rtl/adder_bist.sv
// Built-in self-test controller for N-bit adders: drives directed then LFSR
// operands, checks the (optionally pipelined) DUV response against a reference.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one vector per cycle, NUM_VEC cycles
// DRAIN | LAT cycles for the last responses to arrive
// DONE  | results held until the next start
module adder_bist #(
  parameter int          N       = 128,
  parameter int          LAT     = 0,
  parameter int unsigned NUM_VEC = 30000,
  parameter bit          CHK_PG  = 1'b1,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         cin,
  input  logic [N-1:0] s_duv,
  input  logic         cout_duv,
  input  logic         prop_duv,
  input  logic         gen_duv,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [31:0]  first_fail_idx,
  output logic [31:0]  vec_count
);

  localparam int W = (N + 31) / 32;
  localparam int K = 2 * W + 1;
  localparam logic [31:0]      POLY       = 32'h80200003;
  localparam logic [32*W-1:0]  PAT_W      = {W{32'h55555555}};
  localparam logic [N-1:0]     PAT_P      = PAT_W[N-1:0];
  localparam logic [N-1:0]     ALL1       = '1;
  localparam logic [2:0]       DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  idx;
    logic [N-1:0] s;
    logic         cout;
    logic         prop;
    logic         gen;
  } ref_t;

  state_t state_q, state_d;
  logic [31:0] idx;
  logic [2:0]  drain_cnt;
  logic [31:0] lane [K];
  logic        last_vec;

  logic [32*W-1:0] rnd_a, rnd_b;
  logic [N-1:0]    nxt_a, nxt_b;
  logic            nxt_cin;

  logic [N:0] sum_ab, sum_full;
  ref_t       ref_now, ref_al;
  logic       mismatch;

  function automatic logic [31:0] lane_seed(input int k);
    logic [31:0] s;
    s = SEED ^ (32'(k) * 32'h9E3779B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lane_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  assign last_vec = (idx == NUM_VEC - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last_vec) state_d = (LAT == 0) ? DONE : DRAIN;
      DRAIN:      if (drain_cnt == 3'd0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    rnd_a = '0;
    rnd_b = '0;
    for (int k = 0; k < W; k++) begin
      rnd_a[32*k +: 32] = lane[k];
      rnd_b[32*k +: 32] = lane[W+k];
    end
  end

  // Operands for vector idx+1, registered on the next edge.
  always_comb begin
    nxt_a   = rnd_a[N-1:0];
    nxt_b   = rnd_b[N-1:0];
    nxt_cin = lane[K-1][0];
    unique case (idx)
      32'd0:   begin nxt_a = ALL1;  nxt_b = '0;     nxt_cin = 1'b1; end
      32'd1:   begin nxt_a = ALL1;  nxt_b = ALL1;   nxt_cin = 1'b1; end
      32'd2:   begin nxt_a = PAT_P; nxt_b = ~PAT_P; nxt_cin = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx            <= '0;
      drain_cnt      <= '0;
      a              <= '0;
      b              <= '0;
      cin            <= 1'b0;
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      for (int k = 0; k < K; k++) lane[k] <= lane_seed(k);
    end else begin
      state_q <= state_d;
      if (ref_al.valid && mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) first_fail_idx <= ref_al.idx;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            idx            <= '0;
            vec_count      <= 32'd1;
            a              <= '0;
            b              <= '0;
            cin            <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            for (int k = 0; k < K; k++) lane[k] <= lane_seed(k);
          end
        end
        RUN: begin
          if (last_vec) begin
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            idx       <= idx + 32'd1;
            vec_count <= vec_count + 32'd1;
            a         <= nxt_a;
            b         <= nxt_b;
            cin       <= nxt_cin;
            // Lanes advance only when a random vector is consumed.
            if (idx >= 32'd3)
              for (int k = 0; k < K; k++) lane[k] <= lane_step(lane[k]);
          end
        end
        DRAIN: if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  assign sum_ab   = {1'b0, a} + {1'b0, b};
  assign sum_full = sum_ab + {{N{1'b0}}, cin};

  always_comb begin
    ref_now       = '0;
    ref_now.valid = (state_q == RUN);
    ref_now.idx   = idx;
    ref_now.s     = sum_full[N-1:0];
    ref_now.cout  = sum_full[N];
    ref_now.prop  = &(a ^ b);
    ref_now.gen   = sum_ab[N];
  end

  generate
    if (LAT == 0) begin : g_comb
      assign ref_al = ref_now;
    end else begin : g_pipe
      ref_t pipe [LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < LAT; j++) pipe[j] <= '0;
        end else begin
          pipe[0] <= ref_now;
          for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
      end
      assign ref_al = pipe[LAT-1];
    end
  endgenerate

  always_comb begin
    mismatch = (s_duv != ref_al.s) || (cout_duv != ref_al.cout);
    if (CHK_PG && ((prop_duv != ref_al.prop) || (gen_duv != ref_al.gen)))
      mismatch = 1'b1;
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two instances (wide/pipelined, narrow/combinational)
// driving a behavioural DUV with injectable faults, checked against a vector model.
module tb_adder_bist;

  localparam int          N0 = 100, L0 = 3, NV0 = 300;
  localparam logic [31:0] SEED0 = 32'hACE1;
  localparam int          N1 = 8, L1 = 0, NV1 = 40;
  localparam logic [31:0] SEED1 = 32'h0;

  typedef struct packed {
    logic [255:0] s;
    logic         cout;
    logic         prop;
    logic         gen;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance 0
  logic           start0 = 1'b0;
  logic [N0-1:0]  a0, b0, s_duv0;
  logic           cin0, cout0, prop0, gen0;
  logic           busy0, done0, pass0;
  logic [15:0]    err0;
  logic [31:0]    ffi0, vc0;
  int             fault0 = 0, lat0 = 3;
  res_t           comb0, out0;
  res_t           pipe0 [8];

  // instance 1
  logic           start1 = 1'b0;
  logic [N1-1:0]  a1, b1, s_duv1;
  logic           cin1, cout1, prop1, gen1;
  logic           busy1, done1, pass1;
  logic [15:0]    err1;
  logic [31:0]    ffi1, vc1;
  int             fault1 = 0;
  res_t           out1;

  adder_bist #(.N(N0), .LAT(L0), .NUM_VEC(NV0), .CHK_PG(1'b1), .SEED(SEED0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .s_duv(s_duv0), .cout_duv(cout0), .prop_duv(prop0), .gen_duv(gen0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_idx(ffi0), .vec_count(vc0));

  adder_bist #(.N(N1), .LAT(L1), .NUM_VEC(NV1), .CHK_PG(1'b0), .SEED(SEED1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .s_duv(s_duv1), .cout_duv(cout1), .prop_duv(prop1), .gen_duv(gen1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_idx(ffi1), .vec_count(vc1));

  // Behavioural adder with optional faults: 1 = s[5] stuck-at-0, 2 = gen inverted.
  function automatic res_t adder(input logic [255:0] x, input logic [255:0] y,
                                 input logic c, input int n, input int fault);
    res_t r;
    logic [256:0] ab, full;
    logic [255:0] mask;
    mask   = (256'd1 << n) - 256'd1;
    ab     = {1'b0, x} + {1'b0, y};
    full   = ab + {256'd0, c};
    r.s    = full[255:0] & mask;
    r.cout = full[n];
    r.gen  = ab[n];
    r.prop = (((x ^ y) & mask) == mask);
    if (fault == 1) r.s[5] = 1'b0;
    if (fault == 2) r.gen = ~r.gen;
    return r;
  endfunction

  always_comb comb0 = adder(256'(a0), 256'(b0), cin0, N0, fault0);
  always @(posedge clk) begin
    pipe0[0] <= comb0;
    for (int j = 1; j < 8; j++) pipe0[j] <= pipe0[j-1];
  end
  always_comb begin
    if (lat0 == 0) out0 = comb0;
    else           out0 = pipe0[lat0-1];
    s_duv0 = out0.s[N0-1:0];
    cout0  = out0.cout;
    prop0  = out0.prop;
    gen0   = out0.gen;
  end

  always_comb begin
    out1   = adder(256'(a1), 256'(b1), cin1, N1, fault1);
    s_duv1 = out1.s[N1-1:0];
    cout1  = out1.cout;
    prop1  = out1.prop;
    gen1   = out1.gen;
  end

  // Expected operand stream, rebuilt from the vector rules for each run.
  logic [255:0] mva [$];
  logic [255:0] mvb [$];
  logic         mvc [$];

  task automatic gen_model(input int n, input int nv, input logic [31:0] seed);
    logic [31:0]  ln [17];
    logic [255:0] mask, pat, av, bv;
    int w, k;
    w    = (n + 31) / 32;
    k    = 2 * w + 1;
    mask = (256'd1 << n) - 256'd1;
    pat  = {8{32'h55555555}};
    mva.delete(); mvb.delete(); mvc.delete();
    for (int j = 0; j < k; j++) begin
      ln[j] = seed ^ (32'(j) * 32'h9E3779B9);
      if (ln[j] == 0) ln[j] = 32'h1;
    end
    for (int i = 0; i < nv; i++) begin
      case (i)
        0: begin mva.push_back(0);          mvb.push_back(0);           mvc.push_back(0); end
        1: begin mva.push_back(mask);       mvb.push_back(0);           mvc.push_back(1); end
        2: begin mva.push_back(mask);       mvb.push_back(mask);        mvc.push_back(1); end
        3: begin mva.push_back(pat & mask); mvb.push_back(~pat & mask); mvc.push_back(0); end
        default: begin
          av = 0; bv = 0;
          for (int j = 0; j < w; j++) begin
            av = av | (256'(ln[j]) << (32 * j));
            bv = bv | (256'(ln[w+j]) << (32 * j));
          end
          mva.push_back(av & mask);
          mvb.push_back(bv & mask);
          mvc.push_back(ln[k-1][0]);
          for (int j = 0; j < k; j++) ln[j] = (ln[j] >> 1) ^ (ln[j][0] ? 32'h80200003 : 32'h0);
        end
      endcase
    end
  endtask

  task automatic exp_errors(input int n, input int fault, input bit chk,
                            output int cnt, output int first);
    res_t good, bad;
    cnt = 0; first = 0;
    for (int i = 0; i < mva.size(); i++) begin
      good = adder(mva[i], mvb[i], mvc[i], n, 0);
      bad  = adder(mva[i], mvb[i], mvc[i], n, fault);
      if (good.s != bad.s || good.cout != bad.cout ||
          (chk && (good.prop != bad.prop || good.gen != bad.gen))) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    if (cnt > 65535) cnt = 65535;
  endtask

  int obs_bad, obs_cycles;
  bit obs_idle_zero;
  logic [N1-1:0] oa1 [4];
  logic [N1-1:0] ob1 [4];
  logic          oc1 [4];

  task automatic run0(input int fault, input int lat, input bit mid_start);
    int cyc;
    fault0 = fault; lat0 = lat;
    gen_model(N0, NV0, SEED0);
    obs_bad = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    for (int i = 0; i < NV0; i++) begin
      if (a0 !== mva[i][N0-1:0] || b0 !== mvb[i][N0-1:0] || cin0 !== mvc[i] || busy0 !== 1'b1)
        obs_bad++;
      start0 = mid_start && (i == 5);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    obs_idle_zero = (a0 === '0) && (b0 === '0) && (cin0 === 1'b0);
    cyc = NV0;
    while (done0 !== 1'b1 && cyc < NV0 + 20) begin @(posedge clk); #1; cyc++; end
    obs_cycles = cyc;
  endtask

  task automatic run1(input int fault);
    int cyc;
    fault1 = fault;
    gen_model(N1, NV1, SEED1);
    obs_bad = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    for (int i = 0; i < NV1; i++) begin
      if (i < 4) begin oa1[i] = a1; ob1[i] = b1; oc1[i] = cin1; end
      if (a1 !== mva[i][N1-1:0] || b1 !== mvb[i][N1-1:0] || cin1 !== mvc[i] || busy1 !== 1'b1)
        obs_bad++;
      @(posedge clk); #1;
    end
    obs_idle_zero = (a1 === '0) && (b1 === '0) && (cin1 === 1'b0);
    cyc = NV1;
    while (done1 !== 1'b1 && cyc < NV1 + 20) begin @(posedge clk); #1; cyc++; end
    obs_cycles = cyc;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy0, done0, pass0, err0, ffi0, vc0, a0, b0, cin0} !== '0) begin
      errors++; $display("FAIL reset0: outputs %0h busy=%0b done=%0b vc=%0d, required all 0", a0, busy0, done0, vc0);
    end
    checks++;
    if ({busy1, done1, pass1, err1, ffi1, vc1, a1, b1, cin1} !== '0) begin
      errors++; $display("FAIL reset1: a=%0h busy=%0b done=%0b vc=%0d, required all 0", a1, busy1, done1, vc1);
    end
  endtask

  task automatic test_directed;
    run1(0);
    checks++;
    if ({oa1[0], ob1[0], oc1[0]} !== {8'h00, 8'h00, 1'b0}) begin
      errors++; $display("FAIL dir_v0: a=%0h b=%0h cin=%0b, required 00 00 0", oa1[0], ob1[0], oc1[0]);
    end
    checks++;
    if ({oa1[1], ob1[1], oc1[1]} !== {8'hFF, 8'h00, 1'b1}) begin
      errors++; $display("FAIL dir_v1: a=%0h b=%0h cin=%0b, required ff 00 1", oa1[1], ob1[1], oc1[1]);
    end
    checks++;
    if ({oa1[2], ob1[2], oc1[2]} !== {8'hFF, 8'hFF, 1'b1}) begin
      errors++; $display("FAIL dir_v2: a=%0h b=%0h cin=%0b, required ff ff 1", oa1[2], ob1[2], oc1[2]);
    end
    checks++;
    if ({oa1[3], ob1[3], oc1[3]} !== {8'h55, 8'hAA, 1'b0}) begin
      errors++; $display("FAIL dir_v3: a=%0h b=%0h cin=%0b, required 55 aa 0", oa1[3], ob1[3], oc1[3]);
    end
    checks++;
    if (obs_bad !== 0) begin
      errors++; $display("FAIL vec1_stream: %0d bad vectors, required 0", obs_bad);
    end
    checks++;
    if (obs_cycles !== NV1 || pass1 !== 1'b1 || busy1 !== 1'b0 || vc1 !== 32'(NV1) || !obs_idle_zero) begin
      errors++; $display("FAIL run1_end: cycles=%0d pass=%0b busy=%0b vc=%0d idle0=%0b, required %0d 1 0 %0d 1",
                         obs_cycles, pass1, busy1, vc1, obs_idle_zero, NV1, NV1);
    end
  endtask

  task automatic test_random_ideal;
    run0(0, 3, 1'b1);
    checks++;
    if (obs_bad !== 0) begin
      errors++; $display("FAIL vec0_stream: %0d bad vectors, required 0", obs_bad);
    end
    checks++;
    if (obs_cycles !== NV0 + L0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL done_time0: cycles=%0d busy=%0b, required %0d 0", obs_cycles, busy0, NV0 + L0);
    end
    checks++;
    if (pass0 !== 1'b1 || err0 !== 16'd0 || ffi0 !== 32'd0 || vc0 !== 32'(NV0) || !obs_idle_zero) begin
      errors++; $display("FAIL ideal0: pass=%0b err=%0d ffi=%0d vc=%0d, required 1 0 0 %0d", pass0, err0, ffi0, vc0, NV0);
    end
  endtask

  task automatic test_stuck_s5;
    int ec, ef;
    run0(1, 3, 1'b0);
    exp_errors(N0, 1, 1'b1, ec, ef);
    checks++;
    if (pass0 !== 1'b0 || ffi0 !== 32'd2 || err0 !== 16'(ec) || ef != 2) begin
      errors++; $display("FAIL stuck0: pass=%0b ffi=%0d err=%0d, required 0 2 %0d", pass0, ffi0, err0, ec);
    end
  endtask

  task automatic test_lat_mismatch;
    run0(0, 2, 1'b0);
    checks++;
    if (pass0 !== 1'b0 || done0 !== 1'b1 || ffi0 > 32'd1 || err0 == 16'd0) begin
      errors++; $display("FAIL lat_mis: pass=%0b done=%0b ffi=%0d err=%0d, required 0 1 <=1 >0", pass0, done0, ffi0, err0);
    end
  endtask

  task automatic test_gen_inverted;
    run0(2, 3, 1'b0);
    checks++;
    if (err0 !== 16'(NV0) || ffi0 !== 32'd0 || pass0 !== 1'b0) begin
      errors++; $display("FAIL gen_inv0: err=%0d ffi=%0d pass=%0b, required %0d 0 0", err0, ffi0, pass0, NV0);
    end
    run1(2);
    checks++;
    if (pass1 !== 1'b1 || err1 !== 16'd0) begin
      errors++; $display("FAIL gen_inv1: pass=%0b err=%0d, required 1 0", pass1, err1);
    end
  endtask

  task automatic test_back_to_back;
    int ec, ef;
    for (int r = 0; r < 2; r++) begin
      run1(1);
      exp_errors(N1, 1, 1'b0, ec, ef);
      checks++;
      if (obs_bad !== 0 || err1 !== 16'(ec) || ffi1 !== 32'(ef) || ffi1 !== 32'd2 || vc1 !== 32'(NV1) || pass1 !== 1'b0) begin
        errors++; $display("FAIL b2b_run%0d: bad=%0d err=%0d ffi=%0d vc=%0d, required 0 %0d %0d %0d",
                           r, obs_bad, err1, ffi1, vc1, ec, ef, NV1);
      end
    end
  endtask

  task automatic test_reset_midrun;
    fault0 = 0; lat0 = 3;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b1 || vc0 !== 32'd11) begin
      errors++; $display("FAIL midrun_busy: busy=%0b vc=%0d, required 1 11", busy0, vc0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, pass0, err0, ffi0, vc0, a0, b0, cin0} !== '0) begin
      errors++; $display("FAIL midrun_reset: busy=%0b done=%0b vc=%0d a=%0h, required all 0", busy0, done0, vc0, a0);
    end
    @(negedge clk); rst_n = 1'b1;
    run0(0, 3, 1'b0);
    checks++;
    if (obs_bad !== 0 || vc0 !== 32'(NV0) || pass0 !== 1'b1 || obs_cycles !== NV0 + L0) begin
      errors++; $display("FAIL after_reset: bad=%0d vc=%0d pass=%0b cycles=%0d, required 0 %0d 1 %0d",
                         obs_bad, vc0, pass0, obs_cycles, NV0, NV0 + L0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_directed;
    test_random_ideal;
    test_stuck_s5;
    test_lat_mismatch;
    test_gen_inverted;
    test_back_to_back;
    test_reset_midrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
